// File: rtl/ordered_merge_fsm.sv
// ordered_merge_fsm
//   Moves elements from NUM_CH encoder channels into one output FIFO in
//   ascending index order. Each channel offers one element tagged with an
//   output index. The element whose tag equals the current output index is
//   pushed. When several channels match, a round-robin pointer picks one.
//   An element flagged "last" closes the current index, which then advances
//   and wraps after IDX_MAX. A watchdog re-initialises the block when valid
//   channels keep failing to match.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   out_fifo_full   output FIFO cannot accept a push this cycle
//   out_fifo_clr    clear output FIFO (asserted in INIT)
//   out_fifo_push   push the selected channel data into the output FIFO
//   ch_valid        per-channel element pending
//   ch_index_q      per-channel index tag, channel i at [i*IDX_W +: IDX_W]
//   ch_last         per-channel "last element for this index" flag
//   ch_enable       one-hot data-mux select toward the output FIFO
//   ch_accepted     one-hot consume pulse back to the channel
//   cur_index       current output index
//   stall_err       one-cycle pulse when the watchdog expires
module ordered_merge_fsm #(
  parameter int NUM_CH    = 4,
  parameter int IDX_W     = 10,
  parameter int IDX_MAX   = 1023,
  parameter int STALL_MAX = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      out_fifo_full,
  output logic                      out_fifo_clr,
  output logic                      out_fifo_push,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH*IDX_W-1:0]   ch_index_q,
  input  logic [NUM_CH-1:0]         ch_last,
  output logic [NUM_CH-1:0]         ch_enable,
  output logic [NUM_CH-1:0]         ch_accepted,
  output logic [IDX_W-1:0]          cur_index,
  output logic                      stall_err
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    SCAN = 3'd1,
    HOLD = 3'd2,
    PUSH = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]    grant_idx_q, grant_idx_d;
  logic                grant_last_q, grant_last_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic [NUM_CH-1:0]   match;
  logic                any_match;
  logic [NUM_CH-1:0]   sel_oh;
  logic [PTR_W-1:0]    sel_idx;

  // Index-wrap and pointer-advance helpers
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(IDX_MAX)) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_CH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = ch_valid[i] && (ch_index_q[i*IDX_W +: IDX_W] == out_index_q);
    end
  end

  // Round-robin pick: first matching channel at or above rr_ptr, wrapping.
  always_comb begin
    int pos;
    any_match = 1'b0;
    sel_oh    = '0;
    sel_idx   = '0;
    pos       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!any_match && match[pos]) begin
        any_match   = 1'b1;
        sel_oh[pos] = 1'b1;
        sel_idx     = PTR_W'(pos);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    out_index_d  = out_index_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    grant_last_d = grant_last_q;
    rr_ptr_d     = rr_ptr_q;
    stall_cnt_d  = stall_cnt_q;
    case (state_q)
      INIT: begin
        out_index_d = '0;
        stall_cnt_d = '0;
        state_d     = SCAN;
      end
      SCAN: begin
        if (any_match) begin
          grant_d      = sel_oh;
          grant_idx_d  = sel_idx;
          grant_last_d = ch_last[sel_idx];
          stall_cnt_d  = '0;
          state_d      = out_fifo_full ? HOLD : PUSH;
        end else if (|ch_valid) begin
          // Counter is cleared again in INIT, so no saturation is needed.
          stall_cnt_d = stall_cnt_q + 1'b1;
          if (stall_cnt_q == 16'(STALL_MAX - 1)) state_d = ERR;
        end else begin
          stall_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!out_fifo_full) state_d = PUSH;
      end
      PUSH: begin
        rr_ptr_d = next_ptr(grant_idx_q);
        if (grant_last_q) out_index_d = next_index(out_index_q);
        state_d = SCAN;
      end
      ERR: begin
        state_d = INIT;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // ---- state / control registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      out_index_q <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_index_q <= out_index_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Grant side-information is only consumed in PUSH, after a SCAN load.
  always_ff @(posedge clk) begin
    grant_idx_q  <= grant_idx_d;
    grant_last_q <= grant_last_d;
  end

  // ---- Moore output decode ----
  assign out_fifo_clr  = (state_q == INIT);
  assign out_fifo_push = (state_q == PUSH);
  assign ch_enable     = (state_q == PUSH) ? grant_q : '0;
  assign ch_accepted   = (state_q == PUSH) ? grant_q : '0;
  assign stall_err     = (state_q == ERR);
  assign cur_index     = out_index_q;

endmodule

// File: tb/tb_ordered_merge_fsm.sv
module tb_ordered_merge_fsm;

  localparam int NUM_CH    = 4;
  localparam int IDX_W     = 10;
  localparam int IDX_MAX   = 5;
  localparam int STALL_MAX = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     out_fifo_full = 1'b0;
  logic                     out_fifo_clr;
  logic                     out_fifo_push;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic [NUM_CH*IDX_W-1:0]  ch_index_q = '0;
  logic [NUM_CH-1:0]        ch_last = '0;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH-1:0]        ch_accepted;
  logic [IDX_W-1:0]         cur_index;
  logic                     stall_err;

  int checks = 0;
  int errors = 0;

  ordered_merge_fsm #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .IDX_MAX(IDX_MAX), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .reset(reset), .out_fifo_full(out_fifo_full),
    .out_fifo_clr(out_fifo_clr), .out_fifo_push(out_fifo_push),
    .ch_valid(ch_valid), .ch_index_q(ch_index_q), .ch_last(ch_last),
    .ch_enable(ch_enable), .ch_accepted(ch_accepted),
    .cur_index(cur_index), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic v, input logic [IDX_W-1:0] idx, input logic l);
    ch_valid[i] = v;
    ch_index_q[i*IDX_W +: IDX_W] = idx;
    ch_last[i] = l;
  endtask

  // Leaves the DUT in its first SCAN cycle with all channel inputs idle.
  task automatic do_reset();
    ch_valid = '0; ch_index_q = '0; ch_last = '0; out_fifo_full = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  logic [NUM_CH-1:0] rr_exp [6];
  logic [IDX_W-1:0]  tags [7];
  int push_cnt;
  int err_cnt;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    tags   = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd0};

    // Reset behaviour
    step();
    step();
    chk("rst_clr", 32'(out_fifo_clr), 32'd1);
    chk("rst_push", 32'(out_fifo_push), 32'd0);
    chk("rst_acc", 32'(ch_accepted), 32'd0);
    chk("rst_en", 32'(ch_enable), 32'd0);
    chk("rst_err", 32'(stall_err), 32'd0);
    chk("rst_idx", 32'(cur_index), 32'd0);
    reset = 1'b0;
    chk("rel_clr", 32'(out_fifo_clr), 32'd1);
    step();
    chk("scan_clr", 32'(out_fifo_clr), 32'd0);

    // Single channel, last element closes index 0
    set_ch(2, 1'b1, 10'd0, 1'b1);
    step();
    chk("t1_acc", 32'(ch_accepted), 32'b0100);
    chk("t1_en", 32'(ch_enable), 32'b0100);
    chk("t1_push", 32'(out_fifo_push), 32'd1);
    set_ch(2, 1'b0, 10'd0, 1'b0);
    step();
    chk("t1_push_off", 32'(out_fifo_push), 32'd0);
    chk("t1_idx", 32'(cur_index), 32'd1);

    // Round-robin among ch0, ch1, ch3 on index 0
    do_reset();
    set_ch(0, 1'b1, 10'd0, 1'b0);
    set_ch(1, 1'b1, 10'd0, 1'b0);
    set_ch(3, 1'b1, 10'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rr_acc%0d", k), 32'(ch_accepted), 32'(rr_exp[k]));
      step();
      chk($sformatf("rr_idx%0d", k), 32'(cur_index), 32'd0);
    end
    ch_valid = '0;

    // Index wrap at IDX_MAX
    do_reset();
    push_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wrap_idx%0d", k), 32'(cur_index), 32'(tags[k]));
      set_ch(0, 1'b1, tags[k], 1'b1);
      step();
      if (ch_accepted == 4'b0001 && out_fifo_push) push_cnt++;
      step();
    end
    set_ch(0, 1'b0, 10'd0, 1'b0);
    chk("wrap_pushes", 32'(push_cnt), 32'd7);
    chk("wrap_final", 32'(cur_index), 32'd1);

    // Output FIFO full holds the grant
    do_reset();
    out_fifo_full = 1'b1;
    set_ch(1, 1'b1, 10'd0, 1'b0);
    push_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_fifo_push) push_cnt++;
    end
    chk("full_nopush", 32'(push_cnt), 32'd0);
    out_fifo_full = 1'b0;
    step();
    chk("full_push", 32'(out_fifo_push), 32'd1);
    chk("full_en", 32'(ch_enable), 32'b0010);
    set_ch(1, 1'b0, 10'd0, 1'b0);
    push_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_fifo_push) push_cnt++;
    end
    chk("full_once", 32'(push_cnt), 32'd0);

    // Stall counter cleared by an idle cycle: no watchdog fire
    do_reset();
    err_cnt = 0;
    set_ch(0, 1'b1, 10'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (stall_err) err_cnt++;
      step();
    end
    ch_valid = '0;
    step();
    set_ch(0, 1'b1, 10'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (stall_err) err_cnt++;
      step();
    end
    chk("stall_clear", 32'(err_cnt), 32'd0);

    // Watchdog fires in cycle 5 of a no-match run
    do_reset();
    set_ch(0, 1'b1, 10'd3, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("wd_quiet%0d", c), 32'(stall_err), 32'd0);
      step();
    end
    chk("wd_err", 32'(stall_err), 32'd1);
    set_ch(0, 1'b0, 10'd0, 1'b0);
    step();
    chk("wd_err_off", 32'(stall_err), 32'd0);
    chk("wd_clr", 32'(out_fifo_clr), 32'd1);
    step();
    chk("wd_scan", 32'(out_fifo_clr), 32'd0);
    chk("wd_idx", 32'(cur_index), 32'd0);

    // Reset during a PUSH with grant_last
    do_reset();
    set_ch(2, 1'b1, 10'd0, 1'b1);
    step();
    chk("rp_push", 32'(out_fifo_push), 32'd1);
    reset = 1'b1;
    step();
    chk("rp_nopush", 32'(out_fifo_push), 32'd0);
    chk("rp_idx", 32'(cur_index), 32'd0);
    chk("rp_clr", 32'(out_fifo_clr), 32'd1);
    reset = 1'b0;
    set_ch(2, 1'b0, 10'd0, 1'b0);
    step();
    step();
    chk("rp_idx2", 32'(cur_index), 32'd0);
    chk("rp_nopush2", 32'(out_fifo_push), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
